mic4_pulse_meter: RTL and testbench

Measures digital pulses returned by the mic4 chip on one asynchronous line, such as a hit/readout output or a looped-back A/D pulse. For each pulse it records the width in clock cycles and a timestamp of the rising edge. Results go into a small FIFO that the control/readout logic drains through a valid/ready port. It is the receive-side counterpart of the mic4 control-pulse generator: that block sends stretched pulses to the chip, and this block captures and measures what comes back.

---
 rtl/mic4_pkg.sv | 28 ++
 rtl/mic4_sync_fifo.sv | 57 +++++
 rtl/mic4_pulse_meter.sv | 150 +++++++++++++++
 tb/tb_mic4_pulse_meter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic4_pkg.sv
// mic4_pulse_meter shared definitions.
// FSM encoding, result record layout and default parameters.
package mic4_pkg;

  localparam int DEF_WIDTH_BITS  = 16;
  localparam int DEF_TS_BITS     = 32;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_WIDTH   = 2;

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2
  } state_e;

  // Packing order of one result, MSB first: {width, ts, sat}.
  typedef struct packed {
    logic [DEF_WIDTH_BITS-1:0] width;
    logic [DEF_TS_BITS-1:0]    ts;
    logic                      sat;
  } result_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mic4_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop frees a slot.
module mic4_sync_fifo #(
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic                   pop,
  output logic [DATA_BITS-1:0]   rdata,
  output logic                   valid,
  output logic                   accept,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 do_pop;

  assign valid  = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop & valid;
  assign accept = push & (~full | do_pop);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !do_pop) begin
        count <= count + 1'b1;
      end else if (!accept && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mic4_pulse_meter.sv
// Measures width and rising-edge timestamp of pulses on pulse_in
// and queues {width, ts, sat} results for a valid/ready consumer.
module mic4_pulse_meter
  import mic4_pkg::*;
#(
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int TS_BITS     = DEF_TS_BITS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        clear_ts,
  input  logic                        pulse_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH_BITS-1:0]       out_width,
  output logic [TS_BITS-1:0]          out_ts,
  output logic                        out_sat,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 drop_count,
  output logic                        busy
);

  localparam int DW = WIDTH_BITS + TS_BITS + 1;
  localparam logic [WIDTH_BITS-1:0] MIN_W = WIDTH_BITS'(MIN_WIDTH);
  localparam logic [WIDTH_BITS-1:0] W_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  logic [TS_BITS-1:0]     ts;
  logic [TS_BITS-1:0]     ts_lat;
  logic [WIDTH_BITS-1:0]  width;
  logic                   sat;
  state_e                 state;

  logic                   push_q;
  logic [DW-1:0]          push_data;
  logic [DW-1:0]          head;
  logic                   pop;
  logic                   accept;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign busy = (state == ST_HIGH);
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      ts <= '0;
    end else if (clear_ts) begin
      ts <= '0;
    end else if (enable) begin
      ts <= ts + 1'b1;
    end
  end

  // Results leave through a one-cycle push register so the FIFO
  // write lands one cycle after the fall cycle.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= ST_WAIT_LOW;
      ts_lat    <= '0;
      width     <= '0;
      sat       <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state)
        ST_WAIT_LOW: begin
          if (enable && !s) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!enable) begin
            state <= ST_WAIT_LOW;
          end else if (rise) begin
            ts_lat <= ts;
            width  <= WIDTH_BITS'(1);
            sat    <= 1'b0;
            state  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (!enable) begin
            state <= ST_WAIT_LOW;
          end else if (fall) begin
            if (width >= MIN_W) begin
              push_q    <= 1'b1;
              push_data <= {width, ts_lat, sat};
            end
            state <= ST_IDLE;
          end else if (width == W_MAX) begin
            sat <= 1'b1;
          end else begin
            width <= width + 1'b1;
          end
        end
        default: begin
          state <= ST_WAIT_LOW;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (push_q && !accept) begin
      drop_count <= sat_inc16(drop_count);
    end
  end

  mic4_sync_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .DATA_BITS (DW)
  ) u_fifo (
    .clk    (clk_in),
    .rst_n  (rst),
    .push   (push_q),
    .wdata  (push_data),
    .pop    (pop),
    .rdata  (head),
    .valid  (out_valid),
    .accept (accept),
    .count  (fifo_count)
  );

  assign {out_width, out_ts, out_sat} = head;

endmodule

// File: tb/tb_mic4_pulse_meter.sv
// Scoreboard bench for mic4_pulse_meter: directed corners plus
// randomized pulse trains checked against a pulse-level model.
module tb_mic4_pulse_meter;

  localparam int WB    = 4;
  localparam int TB    = 32;
  localparam int DEPTH = 16;
  localparam int SS    = 2;
  localparam int MINW  = 2;
  localparam int WMAX  = (1 << WB) - 1;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          clear_ts = 1'b0;
  logic          pulse_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [WB-1:0] out_width;
  logic [TB-1:0] out_ts;
  logic          out_sat;
  logic [4:0]    fifo_count;
  logic [15:0]   drop_count;
  logic          busy;

  mic4_pulse_meter #(
    .WIDTH_BITS  (WB),
    .TS_BITS     (TB),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS),
    .MIN_WIDTH   (MINW)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .enable     (enable),
    .clear_ts   (clear_ts),
    .pulse_in   (pulse_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_width  (out_width),
    .out_ts     (out_ts),
    .out_sat    (out_sat),
    .fifo_count (fifo_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          w;
    logic [31:0] ts;
    bit          sat;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_drops = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] model_ts;

  // Timestamp as the chip-side clock sees it: enabled cycles since clear.
  always @(posedge clk_in or negedge rst) begin
    if (!rst) model_ts <= '0;
    else if (clear_ts) model_ts <= '0;
    else if (enable) model_ts <= model_ts + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic exp_t expect_for(input int n);
    exp_t e;
    e.w   = (n > WMAX) ? WMAX : n;
    e.sat = (n > WMAX);
    e.ts  = model_ts + SS;
    return e;
  endfunction

  task automatic pulse(input int n, input int gap);
    if (enable && n >= MINW) begin
      if (exp_q.size() >= DEPTH) exp_drops++;
      else exp_q.push_back(expect_for(n));
    end
    pulse_in = 1'b1;
    ticks(n);
    pulse_in = 1'b0;
    ticks(gap);
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    ticks(2);
    out_ready = 1'b0;
    chk("drain_done", (k >= 300), 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_count", fifo_count, 0);
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got width %0d ts %0h, required none",
                 out_width, out_ts);
      end else begin
        e = exp_q.pop_front();
        chk("out_width", out_width, e.w);
        chk("out_ts", out_ts, e.ts);
        chk("out_sat", out_sat, e.sat);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    int g;
    ticks(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_head", {out_width, out_ts, out_sat}, 0);
    rst = 1'b1;
    ticks(2);

    // single pulse and output latency
    enable = 1'b1;
    clear_ts = 1'b1;
    tick();
    clear_ts = 1'b0;
    ticks(3);
    pulse(5, 0);
    tick();
    chk("lat_e0", out_valid, 0);
    ticks(2);
    chk("lat_e2", out_valid, 0);
    tick();
    chk("lat_e3", out_valid, 1);
    chk("lat_count", fifo_count, 1);
    drain();

    // glitch filter
    pulse(1, 6);
    chk("glitch_count", fifo_count, 0);
    pulse(2, 6);
    drain();

    // saturation
    pulse(20, 4);
    drain();

    // overflow with ready held low
    for (int i = 0; i < 18; i++) pulse(3, 2);
    ticks(4);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_model_drop", drop_count, exp_drops);

    // full FIFO, pop coincides with push
    exp_q.push_back(expect_for(3));
    pulse_in = 1'b1;
    ticks(3);
    pulse_in = 1'b0;
    ticks(3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ticks(3);
    chk("fullpop_count", fifo_count, DEPTH);
    chk("fullpop_drop", drop_count, 2);
    drain();

    // enable rises while input already high
    enable = 1'b0;
    pulse_in = 1'b1;
    ticks(3);
    enable = 1'b1;
    ticks(5);
    pulse_in = 1'b0;
    ticks(4);
    chk("late_en_count", fifo_count, 0);
    chk("late_en_busy", busy, 0);
    pulse(6, 4);
    drain();

    // enable drops mid-pulse
    pulse_in = 1'b1;
    ticks(4);
    chk("mid_busy", busy, 1);
    enable = 1'b0;
    ticks(2);
    chk("mid_off_busy", busy, 0);
    enable = 1'b1;
    ticks(4);
    pulse_in = 1'b0;
    ticks(5);
    chk("mid_count", fifo_count, 0);

    // randomized pulse trains with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      do n = $urandom_range(1, 20); while (n == WMAX);
      g = $urandom_range(1, 5);
      if ($urandom_range(0, 7) == 0) begin
        clear_ts = 1'b1;
        tick();
        clear_ts = 1'b0;
      end
      pulse(n, g);
    end
    rand_ready = 1'b0;
    drain();
    chk("rand_drop", drop_count, exp_drops);

    // reset mid-pulse with entries pending
    pulse(4, 3);
    pulse(4, 3);
    pulse_in = 1'b1;
    ticks(5);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_count", fifo_count, 2);
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_head", {out_width, out_ts, out_sat}, 0);
    exp_q.delete();
    pulse_in = 1'b0;
    ticks(3);
    rst = 1'b1;
    ticks(5);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
